// File: rtl/npc_bpred.sv
// Next-PC unit: fetch PC register, tagged BTB with 2-bit counters,
// and EX-stage branch resolution raising flush on misprediction.
module npc_bpred #(
  parameter int              XLEN      = 32,
  parameter int              BTB_DEPTH = 64,
  parameter logic [XLEN-1:0] RESET_PC  = 32'hBFC0_0000,
  parameter logic [1:0]      CNT_INIT  = 2'b01,
  parameter int              STAT_W    = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              if_stall,
  output logic [XLEN-1:0]   pc,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              ex_br_valid,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [2:0]        ex_cmp_op,
  input  logic [XLEN-1:0]   ex_cmp1,
  input  logic [XLEN-1:0]   ex_cmp2,
  input  logic [XLEN-1:0]   ex_imm,
  input  logic [25:0]       ex_jidx,
  input  logic              ex_pred_taken,
  input  logic [XLEN-1:0]   ex_pred_target,
  output logic              flush,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [STAT_W-1:0] mispredict_cnt,
  output logic [STAT_W-1:0] branch_cnt
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  logic             btb_v   [BTB_DEPTH];
  logic [TAG_W-1:0] btb_tag [BTB_DEPTH];
  logic [XLEN-1:0]  btb_tgt [BTB_DEPTH];
  logic [1:0]       btb_cnt [BTB_DEPTH];

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             rd_hit;
  logic             wr_hit;

  assign rd_idx = pc[IDX_W+1:2];
  assign rd_hit = btb_v[rd_idx] &&
                  (btb_tag[rd_idx] == pc[XLEN-1:IDX_W+2]);

  assign pred_taken  = rd_hit && btb_cnt[rd_idx][1];
  assign pred_target = pred_taken ? btb_tgt[rd_idx] : pc + FOUR;

  logic            ex_v;
  logic            taken;
  logic            mis;
  logic            neg;
  logic            zero;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] j_tgt;
  logic [XLEN-1:0] tgt;

  // EX inputs are ignored while reset is held
  assign ex_v   = ex_br_valid && resetn;
  assign neg    = ex_cmp1[XLEN-1];
  assign zero   = ~|ex_cmp1;
  assign seq_pc = ex_pc + FOUR;
  assign br_tgt = seq_pc + (ex_imm << 2);
  assign j_tgt  = {seq_pc[XLEN-1:28], ex_jidx, 2'b00};
  assign tgt    = (ex_cmp_op == 3'd6) ? j_tgt : br_tgt;

  always_comb begin
    taken = 1'b0;
    unique case (ex_cmp_op)
      3'd0:    taken = ex_cmp1 == ex_cmp2;
      3'd1:    taken = ex_cmp1 != ex_cmp2;
      3'd2:    taken = neg || zero;
      3'd3:    taken = !neg && !zero;
      3'd4:    taken = neg;
      3'd5:    taken = !neg;
      3'd6:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  assign mis = ex_v && ((taken != ex_pred_taken) ||
               (taken && (ex_pred_target != tgt)));

  assign flush       = mis;
  assign redirect_pc = taken ? tgt : seq_pc;

  assign wr_idx = ex_pc[IDX_W+1:2];
  assign wr_hit = btb_v[wr_idx] &&
                  (btb_tag[wr_idx] == ex_pc[XLEN-1:IDX_W+2]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc             <= RESET_PC;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      if (mis)
        pc <= redirect_pc;
      else if (!if_stall)
        pc <= pred_target;
      if (ex_v && ~&branch_cnt)
        branch_cnt <= branch_cnt + STAT_W'(1);
      if (mis && ~&mispredict_cnt)
        mispredict_cnt <= mispredict_cnt + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_v[i]   <= 1'b0;
        btb_tag[i] <= '0;
        btb_tgt[i] <= '0;
        btb_cnt[i] <= CNT_INIT;
      end
    end else if (ex_v) begin
      if (wr_hit) begin
        if (taken) begin
          btb_tgt[wr_idx] <= tgt;
          if (btb_cnt[wr_idx] != 2'b11)
            btb_cnt[wr_idx] <= btb_cnt[wr_idx] + 2'd1;
        end else if (btb_cnt[wr_idx] != 2'b00) begin
          btb_cnt[wr_idx] <= btb_cnt[wr_idx] - 2'd1;
        end
      end else if (taken) begin
        btb_v[wr_idx]   <= 1'b1;
        btb_tag[wr_idx] <= ex_pc[XLEN-1:IDX_W+2];
        btb_tgt[wr_idx] <= tgt;
        btb_cnt[wr_idx] <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_npc_bpred.sv
// Scoreboard bench for npc_bpred: expectations are queued as stimulus
// is driven and compared against DUT observations per scenario.
module tb_npc_bpred;

  localparam int SW = 4;
  localparam int SMAX = 15;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          if_stall = 1'b0;
  logic [31:0]   pc;
  logic          pred_taken;
  logic [31:0]   pred_target;
  logic          ex_br_valid = 1'b0;
  logic [31:0]   ex_pc = '0;
  logic [2:0]    ex_cmp_op = '0;
  logic [31:0]   ex_cmp1 = '0;
  logic [31:0]   ex_cmp2 = '0;
  logic [31:0]   ex_imm = '0;
  logic [25:0]   ex_jidx = '0;
  logic          ex_pred_taken = 1'b0;
  logic [31:0]   ex_pred_target = '0;
  logic          flush;
  logic [31:0]   redirect_pc;
  logic [SW-1:0] mispredict_cnt;
  logic [SW-1:0] branch_cnt;

  always #5 clk = ~clk;

  npc_bpred #(
    .XLEN(32), .BTB_DEPTH(64), .RESET_PC(32'hBFC0_0000),
    .CNT_INIT(2'b01), .STAT_W(SW)
  ) dut (
    .clk(clk), .resetn(resetn), .if_stall(if_stall),
    .pc(pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_br_valid(ex_br_valid), .ex_pc(ex_pc), .ex_cmp_op(ex_cmp_op),
    .ex_cmp1(ex_cmp1), .ex_cmp2(ex_cmp2), .ex_imm(ex_imm),
    .ex_jidx(ex_jidx), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .flush(flush),
    .redirect_pc(redirect_pc), .mispredict_cnt(mispredict_cnt),
    .branch_cnt(branch_cnt)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] obs[$];
  int          tests = 0;
  int          fails = 0;
  int          m_br = 0;
  int          m_mis = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_v(input string n, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.exp  = v;
    sb.push_back(e);
  endtask

  // Saturating statistics model
  task automatic note(input bit mis);
    m_br = (m_br < SMAX) ? m_br + 1 : SMAX;
    if (mis) m_mis = (m_mis < SMAX) ? m_mis + 1 : SMAX;
  endtask

  task automatic drive_br(input logic [31:0] p, input logic [2:0] op,
                          input logic [31:0] c1, input logic [31:0] c2,
                          input logic [31:0] imm, input logic [25:0] j,
                          input logic pt, input logic [31:0] ptg);
    ex_br_valid    = 1'b1;
    ex_pc          = p;
    ex_cmp_op      = op;
    ex_cmp1        = c1;
    ex_cmp2        = c2;
    ex_imm         = imm;
    ex_jidx        = j;
    ex_pred_taken  = pt;
    ex_pred_target = ptg;
  endtask

  task automatic idle();
    ex_br_valid = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [31:0] o;
    @(negedge clk);
    resetn = 1'b1;
    tick();
    drive_br(32'hBFC00300, 3'd1, 32'd7, 32'd7, 32'd0, 26'd0, 1'b0,
             32'hBFC00304);
    note(1'b0);
    tick();
    idle();
    expect_v("pre_reset_branch_cnt", 32'(m_br));
    obs.push_back(32'(branch_cnt));
    #2;
    drive_br(32'hBFC00004, 3'd0, 32'd5, 32'd5, 32'd3, 26'd0, 1'b0,
             32'hBFC00008);
    resetn = 1'b0;
    m_br  = 0;
    m_mis = 0;
    #1;
    expect_v("rst_pc", 32'hBFC00000);       obs.push_back(pc);
    expect_v("rst_pred_taken", 32'd0);      obs.push_back(32'(pred_taken));
    expect_v("rst_pred_target", 32'hBFC00004); obs.push_back(pred_target);
    expect_v("rst_flush", 32'd0);           obs.push_back(32'(flush));
    expect_v("rst_branch_cnt", 32'd0);      obs.push_back(32'(branch_cnt));
    expect_v("rst_mis_cnt", 32'd0);         obs.push_back(32'(mispredict_cnt));
    tick();
    expect_v("rst_hold_pc", 32'hBFC00000);  obs.push_back(pc);
    idle();
    @(negedge clk);
    resetn = 1'b1;
    tick();
    expect_v("seq_pc1", 32'hBFC00004);      obs.push_back(pc);
    expect_v("seq_pred1", 32'd0);           obs.push_back(32'(pred_taken));
    tick();
    expect_v("seq_pc2", 32'hBFC00008);      obs.push_back(pc);
    expect_v("seq_pred2", 32'd0);           obs.push_back(32'(pred_taken));
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      tests++;
      if (o !== e.exp) begin
        fails++;
        $display("FAIL %s: got %h, expected %h", e.name, o, e.exp);
      end
    end
  endtask

  task automatic test_cold_taken();
    exp_t e;
    logic [31:0] o;
    drive_br(32'hBFC00010, 3'd0, 32'd5, 32'd5, 32'd3, 26'd0, 1'b0,
             32'hBFC00014);
    note(1'b1);
    @(negedge clk);
    expect_v("cold_flush", 32'd1);          obs.push_back(32'(flush));
    expect_v("cold_redirect", 32'hBFC00020); obs.push_back(redirect_pc);
    tick();
    idle();
    expect_v("cold_pc", 32'hBFC00020);      obs.push_back(pc);
    expect_v("cold_mis_cnt", 32'(m_mis));   obs.push_back(32'(mispredict_cnt));
    expect_v("cold_br_cnt", 32'(m_br));     obs.push_back(32'(branch_cnt));
    drive_br(32'hBFC0000C, 3'd7, 32'd0, 32'd0, 32'd0, 26'd0, 1'b1,
             32'hBFC00010);
    note(1'b1);
    tick();
    idle();
    expect_v("cold_back_pc", 32'hBFC00010); obs.push_back(pc);
    expect_v("cold_pred", 32'd1);           obs.push_back(32'(pred_taken));
    expect_v("cold_pred_tgt", 32'hBFC00020); obs.push_back(pred_target);
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      tests++;
      if (o !== e.exp) begin
        fails++;
        $display("FAIL %s: got %h, expected %h", e.name, o, e.exp);
      end
    end
  endtask

  task automatic test_train_down();
    exp_t e;
    logic [31:0] o;
    drive_br(32'hBFC00010, 3'd0, 32'd1, 32'd2, 32'd3, 26'd0, 1'b1,
             32'hBFC00020);
    note(1'b1);
    @(negedge clk);
    expect_v("down_flush", 32'd1);          obs.push_back(32'(flush));
    expect_v("down_redirect", 32'hBFC00014); obs.push_back(redirect_pc);
    tick();
    idle();
    expect_v("down_pc", 32'hBFC00014);      obs.push_back(pc);
    drive_br(32'hBFC0000C, 3'd7, 32'd0, 32'd0, 32'd0, 26'd0, 1'b1,
             32'hBFC00010);
    note(1'b1);
    tick();
    idle();
    expect_v("down_back_pc", 32'hBFC00010); obs.push_back(pc);
    expect_v("down_pred", 32'd0);           obs.push_back(32'(pred_taken));
    expect_v("down_pred_tgt", 32'hBFC00014); obs.push_back(pred_target);
    drive_br(32'hBFC00010, 3'd0, 32'd1, 32'd2, 32'd3, 26'd0, 1'b0,
             32'hBFC00014);
    note(1'b0);
    @(negedge clk);
    expect_v("ok_flush", 32'd0);            obs.push_back(32'(flush));
    tick();
    idle();
    expect_v("ok_pc", 32'hBFC00014);        obs.push_back(pc);
    expect_v("ok_br_cnt", 32'(m_br));       obs.push_back(32'(branch_cnt));
    expect_v("ok_mis_cnt", 32'(m_mis));     obs.push_back(32'(mispredict_cnt));
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      tests++;
      if (o !== e.exp) begin
        fails++;
        $display("FAIL %s: got %h, expected %h", e.name, o, e.exp);
      end
    end
  endtask

  task automatic test_signed();
    exp_t e;
    logic [31:0] o;
    logic [2:0]  ops [7] = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd5, 3'd0, 3'd2};
    logic [31:0] c1s [7] = '{32'hFFFFFFFF, 32'h80000000, 32'd0, 32'd7,
                             32'd0, 32'd3, 32'd1};
    logic [31:0] c2s [7] = '{32'd0, 32'd0, 32'd0, 32'd7, 32'd0, 32'd3,
                             32'd0};
    logic [31:0] imms [7] = '{32'd4, 32'd4, 32'd2, 32'd4, 32'd1,
                              32'hFFFFFFFF, 32'd4};
    bit          tks [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      logic [31:0] p;
      logic [31:0] t;
      p = 32'hBFC00200 + 32'(i * 16);
      t = p + 32'd4 + (imms[i] << 2);
      drive_br(p, ops[i], c1s[i], c2s[i], imms[i], 26'd0, 1'b0, p + 32'd4);
      note(tks[i]);
      @(negedge clk);
      expect_v($sformatf("signed%0d_flush", i), 32'(tks[i]));
      obs.push_back(32'(flush));
      if (tks[i]) begin
        expect_v($sformatf("signed%0d_redirect", i), t);
        obs.push_back(redirect_pc);
      end
      tick();
      idle();
      if (tks[i]) begin
        expect_v($sformatf("signed%0d_pc", i), t);
        obs.push_back(pc);
      end
    end
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      tests++;
      if (o !== e.exp) begin
        fails++;
        $display("FAIL %s: got %h, expected %h", e.name, o, e.exp);
      end
    end
  endtask

  task automatic test_stall_flush();
    exp_t e;
    logic [31:0] o;
    drive_br(32'hBFC001FC, 3'd7, 32'd0, 32'd0, 32'd0, 26'd0, 1'b1,
             32'hBFC00200);
    note(1'b1);
    tick();
    idle();
    if_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_v($sformatf("stall%0d_pc", i), 32'hBFC00200);
      obs.push_back(pc);
      expect_v($sformatf("stall%0d_pred", i), 32'd1);
      obs.push_back(32'(pred_taken));
      expect_v($sformatf("stall%0d_tgt", i), 32'hBFC00214);
      obs.push_back(pred_target);
    end
    drive_br(32'hBFC00100, 3'd6, 32'd0, 32'd0, 32'd0, 26'h40, 1'b0,
             32'hBFC00104);
    note(1'b1);
    @(negedge clk);
    expect_v("stall_j_flush", 32'd1);       obs.push_back(32'(flush));
    expect_v("stall_j_redirect", 32'hB0000100); obs.push_back(redirect_pc);
    tick();
    idle();
    expect_v("stall_j_pc", 32'hB0000100);   obs.push_back(pc);
    drive_br(32'hBFC00010, 3'd0, 32'd5, 32'd5, 32'd3, 26'd0, 1'b1,
             32'hBFC00024);
    note(1'b1);
    @(negedge clk);
    expect_v("tgt_mis_flush", 32'd1);       obs.push_back(32'(flush));
    expect_v("tgt_mis_redirect", 32'hBFC00020); obs.push_back(redirect_pc);
    tick();
    idle();
    expect_v("tgt_mis_pc", 32'hBFC00020);   obs.push_back(pc);
    tick();
    expect_v("stall_after_pc", 32'hBFC00020); obs.push_back(pc);
    if_stall = 1'b0;
    expect_v("stall_br_cnt", 32'(m_br));    obs.push_back(32'(branch_cnt));
    expect_v("stall_mis_cnt", 32'(m_mis));  obs.push_back(32'(mispredict_cnt));
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      tests++;
      if (o !== e.exp) begin
        fails++;
        $display("FAIL %s: got %h, expected %h", e.name, o, e.exp);
      end
    end
  endtask

  task automatic test_counter_sat();
    exp_t e;
    logic [31:0] o;
    bit tk [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bit pr [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    drive_br(32'hBFC005FC, 3'd7, 32'd0, 32'd0, 32'd0, 26'd0, 1'b1,
             32'hBFC00600);
    note(1'b1);
    tick();
    idle();
    if_stall = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive_br(32'hBFC00600, 3'd0, 32'd5, tk[i] ? 32'd5 : 32'd6, 32'd8,
               26'd0, tk[i], tk[i] ? 32'hBFC00624 : 32'hBFC00604);
      note(1'b0);
      @(negedge clk);
      if (i == 0) begin
        expect_v("same_cycle_pred", 32'd0);
        obs.push_back(32'(pred_taken));
      end
      expect_v($sformatf("ctr%0d_flush", i), 32'd0);
      obs.push_back(32'(flush));
      tick();
      idle();
      expect_v($sformatf("ctr%0d_pred", i), 32'(pr[i]));
      obs.push_back(32'(pred_taken));
      expect_v($sformatf("ctr%0d_tgt", i),
               pr[i] ? 32'hBFC00624 : 32'hBFC00604);
      obs.push_back(pred_target);
    end
    expect_v("ctr_hold_pc", 32'hBFC00600);  obs.push_back(pc);
    if_stall = 1'b0;
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      tests++;
      if (o !== e.exp) begin
        fails++;
        $display("FAIL %s: got %h, expected %h", e.name, o, e.exp);
      end
    end
  endtask

  task automatic test_jump_sat();
    exp_t e;
    logic [31:0] o;
    drive_br(32'hBFC00100, 3'd6, 32'd0, 32'd0, 32'd0, 26'h40, 1'b0,
             32'hBFC00104);
    note(1'b1);
    @(negedge clk);
    expect_v("jump_flush", 32'd1);          obs.push_back(32'(flush));
    expect_v("jump_redirect", 32'hB0000100); obs.push_back(redirect_pc);
    tick();
    idle();
    expect_v("jump_pc", 32'hB0000100);      obs.push_back(pc);
    drive_br(32'hBFC00100, 3'd6, 32'd0, 32'd0, 32'd0, 26'h40, 1'b1,
             32'hB0000100);
    note(1'b0);
    @(negedge clk);
    expect_v("jump_ok_flush", 32'd0);       obs.push_back(32'(flush));
    tick();
    idle();
    for (int i = 0; i < 20; i++) begin
      drive_br(32'hBFC00500, 3'd7, 32'd0, 32'd0, 32'd0, 26'd0, 1'b1,
               32'hBFC00504);
      note(1'b1);
      tick();
      expect_v($sformatf("sat%0d_mis_cnt", i), 32'(m_mis));
      obs.push_back(32'(mispredict_cnt));
    end
    idle();
    expect_v("sat_mis_final", 32'hF);       obs.push_back(32'(mispredict_cnt));
    expect_v("sat_br_final", 32'hF);        obs.push_back(32'(branch_cnt));
    while (sb.size() > 0 && obs.size() > 0) begin
      e = sb.pop_front();
      o = obs.pop_front();
      tests++;
      if (o !== e.exp) begin
        fails++;
        $display("FAIL %s: got %h, expected %h", e.name, o, e.exp);
      end
    end
  endtask

  initial begin
    tick();
    tick();
    test_reset();
    test_cold_taken();
    test_train_down();
    test_signed();
    test_stall_flush();
    test_counter_sat();
    test_jump_sat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
